eoc_readout: RTL and testbench
==============================

EOC_READOUT -- requirements
Module: eoc_readout

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, output record FIFO depth (power of 2, >=2).
REQ-002 SHALL have parameter MAX_HITS, default 255, the hit cap per trigger.
REQ-003 SHALL have parameter TK_TIMEOUT, default 15, the cycles to wait for tk after a header.
REQ-004 SHALL have port clock  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports trig_valid in 1, trig_id in 4, trig_ready out 1: the trigger-readout request handshake.
REQ-007 SHALL have port TrigIdReq  out  4  trigger ID presented to the token/column stage.
REQ-008 SHALL have port read  out  1  hit read strobe to the token/column stage.
REQ-009 SHALL have ports tk in 3, row_hamm in 12, clm_hamm in 10, data_hamm in 25: the hit source; tk==3'b111 means hits pending.
REQ-010 SHALL have ports fifo_rd in 1, fifo_dout out 49, fifo_empty out 1, fifo_full out 1: the show-ahead record FIFO read side.

Function
REQ-011 SHALL implement states IDLE, HEADER, WAIT_TK, STROBE, HOLD, CAPTURE, TRAILER.
REQ-012 SHALL drive trig_ready=1 only in IDLE; on trig_valid&trig_ready, latch trig_id into TrigIdReq, clear hit_cnt and timer, and go to HEADER.
REQ-013 HEADER SHALL push {2'b01, 43'b0, TrigIdReq} when the FIFO is not full, then go to WAIT_TK; when full it SHALL stall.
REQ-014 WAIT_TK SHALL go to STROBE if tk==3'b111; otherwise it SHALL increment the timer, and when the timer reaches TK_TIMEOUT it SHALL set the timeout flag and go to TRAILER.
REQ-015 When tk!=3'b111 in WAIT_TK with hit_cnt>0, the block SHALL go to TRAILER immediately, because all hits have been drained.
REQ-016 STROBE and HOLD SHALL each drive read=1 for one cycle; read SHALL be 0 in every other state, so each hit produces exactly one rising edge.
REQ-017 CAPTURE SHALL sample row_hamm, clm_hamm and data_hamm (stable two cycles after the read rising edge).
REQ-018 CAPTURE SHALL push {2'b10, clm_hamm, row_hamm, data_hamm} when the FIFO is not full, increment hit_cnt, and return to WAIT_TK with the timer cleared; when full it SHALL stall in CAPTURE with read=0.
REQ-019 When hit_cnt reaches MAX_HITS after a push, the block SHALL set the overflow flag and go to TRAILER without further strobes.
REQ-020 TRAILER SHALL push {2'b11, 29'b0, timeout, overflow, hit_cnt[15:0]} when the FIFO is not full, then return to IDLE.
REQ-021 hit_cnt SHALL be 16 bits wide and saturate at MAX_HITS.
REQ-022 The FIFO SHALL be first-in first-out, with fifo_dout showing the oldest word whenever fifo_empty=0.
REQ-023 fifo_rd while empty SHALL be ignored; a push while full SHALL never occur.
REQ-024 A simultaneous push and pop SHALL be allowed at every occupancy, including full (the word count stays unchanged).
REQ-025 fifo_full SHALL equal (count==FIFO_DEPTH); pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 trig_valid outside IDLE SHALL be ignored and not queued.

Reset
REQ-027 On reset, the block SHALL enter IDLE with read=0, TrigIdReq=0, hit_cnt=0, timer=0 and both flags cleared.
REQ-028 On reset, the FIFO SHALL be emptied (fifo_empty=1, fifo_full=0, fifo_dout=0).
REQ-029 Reset mid-trigger SHALL abort the trigger with no trailer emitted; the first record after reset SHALL be a header.

Structure
REQ-030 The record type codes (HDR=2'b01, HIT=2'b10, TRL=2'b11), the record width of 49, and the state encoding SHALL live in shared package eoc_pkg.
REQ-031 The FIFO SHALL be a sub-module eoc_fifo (parameterised width and depth, show-ahead).

Verification
REQ-032 Bench SHALL cover: trig_id=5 with 3 pending hits -> header ID 5, 3 hit records in strobe order, trailer hit_cnt=3 with both flags 0, read high exactly 2 cycles per hit.
REQ-033 Bench SHALL cover: trig_id=2 with tk held 0 -> header, then trailer with timeout=1 and hit_cnt=0 at TK_TIMEOUT+1 cycles after WAIT_TK entry.
REQ-034 Bench SHALL cover: MAX_HITS=4 with tk held 3'b111 -> 4 hits, trailer overflow=1, hit_cnt=4, no fifth read edge.
REQ-035 Bench SHALL cover: FIFO_DEPTH=2 with fifo_rd=0 and 3 hits -> stall in CAPTURE with read=0; releasing fifo_rd resumes with no record lost or duplicated.
REQ-036 Bench SHALL cover: FIFO full with simultaneous push and pop -> fifo_full stays 1 and the next word is correct.
REQ-037 Bench SHALL cover: reset asserted in HOLD -> read=0 and fifo_empty=1 immediately, and the next trigger starts with a header.

Source files
------------

// File: rtl/eoc_pkg.sv
// Shared record codes, record width and FSM states for the EOC readout.
// Imported by eoc_fifo and eoc_readout.
package eoc_pkg;

   localparam int REC_W = 49;

   localparam logic [1:0] REC_HDR = 2'b01;
   localparam logic [1:0] REC_HIT = 2'b10;
   localparam logic [1:0] REC_TRL = 2'b11;

   localparam logic [2:0] TK_PEND = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_WAIT_TK,
      S_STROBE,
      S_HOLD,
      S_CAPTURE,
      S_TRAILER
   } state_e;

endpackage

// File: rtl/eoc_fifo.sv
// Show-ahead FIFO: dout shows the oldest word while not empty, else 0.
// Ports: clock, reset, wr_en/din push, rd_en pop, dout, empty, full.
import eoc_pkg::*;

module eoc_fifo #(
   parameter int WIDTH = REC_W,
   parameter int DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_wr;
   logic             do_rd;

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));
   assign do_rd = rd_en && !empty;
   // a push at full is legal only when a pop frees the slot
   assign do_wr = wr_en && (!full || do_rd);
   assign dout  = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_wr) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/eoc_readout.sv
// End-of-column trigger readout: header, strobed hits, trailer into FIFO.
// Ports: trig handshake, TrigIdReq/read to columns, tk+hamm in, FIFO out.
import eoc_pkg::*;

module eoc_readout #(
   parameter int FIFO_DEPTH = 8,
   parameter int MAX_HITS   = 255,
   parameter int TK_TIMEOUT = 15
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             trig_valid,
   input  logic [3:0]       trig_id,
   output logic             trig_ready,
   output logic [3:0]       TrigIdReq,
   output logic             read,
   input  logic [2:0]       tk,
   input  logic [11:0]      row_hamm,
   input  logic [9:0]       clm_hamm,
   input  logic [24:0]      data_hamm,
   input  logic             fifo_rd,
   output logic [REC_W-1:0] fifo_dout,
   output logic             fifo_empty,
   output logic             fifo_full
);

   localparam logic [15:0] MAX_W = 16'(MAX_HITS);
   localparam logic [15:0] TO_W  = 16'(TK_TIMEOUT);

   state_e           state;
   logic [15:0]      hit_cnt;
   logic [15:0]      timer;
   logic             timeout_f;
   logic             overflow_f;
   logic             push;
   logic [REC_W-1:0] push_data;

   assign trig_ready = (state == S_IDLE);

   always_comb begin
      push      = 1'b0;
      push_data = '0;
      case (state)
         S_HEADER: begin
            push      = !fifo_full;
            push_data = {REC_HDR, 43'b0, TrigIdReq};
         end
         S_CAPTURE: begin
            push      = !fifo_full;
            push_data = {REC_HIT, clm_hamm, row_hamm, data_hamm};
         end
         S_TRAILER: begin
            push      = !fifo_full;
            push_data = {REC_TRL, 29'b0, timeout_f, overflow_f, hit_cnt};
         end
         default: ;
      endcase
   end

   // read is set on entry to STROBE and cleared on entry to CAPTURE,
   // giving one two-cycle pulse per hit
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         read       <= 1'b0;
         TrigIdReq  <= '0;
         hit_cnt    <= '0;
         timer      <= '0;
         timeout_f  <= 1'b0;
         overflow_f <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (trig_valid) begin
                  TrigIdReq  <= trig_id;
                  hit_cnt    <= '0;
                  timer      <= '0;
                  timeout_f  <= 1'b0;
                  overflow_f <= 1'b0;
                  state      <= S_HEADER;
               end
            end
            S_HEADER: begin
               if (!fifo_full) state <= S_WAIT_TK;
            end
            S_WAIT_TK: begin
               if (tk == TK_PEND) begin
                  read  <= 1'b1;
                  state <= S_STROBE;
               end else if (hit_cnt != '0) begin
                  // token gone after at least one hit: column drained
                  state <= S_TRAILER;
               end else begin
                  timer <= timer + 16'd1;
                  if (timer + 16'd1 == TO_W) begin
                     timeout_f <= 1'b1;
                     state     <= S_TRAILER;
                  end
               end
            end
            S_STROBE: state <= S_HOLD;
            S_HOLD: begin
               read  <= 1'b0;
               state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               if (!fifo_full) begin
                  hit_cnt <= hit_cnt + 16'd1;
                  timer   <= '0;
                  if (hit_cnt + 16'd1 == MAX_W) begin
                     overflow_f <= 1'b1;
                     state      <= S_TRAILER;
                  end else begin
                     state <= S_WAIT_TK;
                  end
               end
            end
            S_TRAILER: begin
               if (!fifo_full) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   eoc_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .wr_en (push),
      .din   (push_data),
      .rd_en (fifo_rd),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule

// File: tb/tb_eoc_readout.sv
// Randomised bench for eoc_readout with a record-stream reference model.
// Also exercises a standalone eoc_fifo for push+pop at full.
module tb_eoc_readout;

   localparam int DEPTH = 2;
   localparam int MAXH  = 4;
   localparam int TKTO  = 15;

   logic        clock;
   logic        reset;
   logic        trig_valid;
   logic [3:0]  trig_id;
   logic        trig_ready;
   logic [3:0]  TrigIdReq;
   logic        read;
   logic [2:0]  tk;
   logic [11:0] row_hamm;
   logic [9:0]  clm_hamm;
   logic [24:0] data_hamm;
   logic        fifo_rd;
   logic [48:0] fifo_dout;
   logic        fifo_empty;
   logic        fifo_full;

   logic        f_wr;
   logic [7:0]  f_din;
   logic        f_rd;
   logic [7:0]  f_dout;
   logic        f_empty;
   logic        f_full;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          edges = 0;
   int          run = 0;
   logic        read_q = 0;
   int          rd_mode = 0;
   int          t_hdr = 0;
   int          t_trl = 0;
   logic [48:0] last_hdr = '0;
   logic [48:0] last_trl = '0;
   logic [1:0]  first_type = '0;
   logic        first_seen = 0;
   logic [46:0] src_q [$];
   logic [48:0] exp_q [$];

   eoc_readout #(
      .FIFO_DEPTH (DEPTH),
      .MAX_HITS   (MAXH),
      .TK_TIMEOUT (TKTO)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .trig_valid (trig_valid),
      .trig_id    (trig_id),
      .trig_ready (trig_ready),
      .TrigIdReq  (TrigIdReq),
      .read       (read),
      .tk         (tk),
      .row_hamm   (row_hamm),
      .clm_hamm   (clm_hamm),
      .data_hamm  (data_hamm),
      .fifo_rd    (fifo_rd),
      .fifo_dout  (fifo_dout),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full)
   );

   eoc_fifo #(
      .WIDTH (8),
      .DEPTH (2)
   ) u_sf (
      .clock (clock),
      .reset (reset),
      .wr_en (f_wr),
      .din   (f_din),
      .rd_en (f_rd),
      .dout  (f_dout),
      .empty (f_empty),
      .full  (f_full)
   );

   initial clock = 0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   // hit source, read pulse monitor and consumer with stream compare
   always @(negedge clock) begin
      cyc++;
      if (reset) begin
         run    = 0;
         read_q = 0;
         fifo_rd = 0;
      end else begin
         if (read) begin
            if (!read_q) begin
               edges++;
               if (src_q.size() > 0)
                  {clm_hamm, row_hamm, data_hamm} = src_q.pop_front();
            end
            run++;
         end else if (read_q) begin
            chk("read_width", 64'(run), 64'd2);
            run = 0;
         end
         read_q = read;
         tk = (src_q.size() > 0) ? 3'b111 : 3'($urandom_range(0, 6));
         case (rd_mode)
            1:       fifo_rd = 0;
            2:       fifo_rd = 1;
            default: fifo_rd = ($urandom_range(0, 3) != 0);
         endcase
         if (!fifo_empty) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_word: got %0h required none", fifo_dout);
            end else begin
               chk("fifo_dout", 64'(fifo_dout), 64'(exp_q[0]));
               if (fifo_rd) begin
                  void'(exp_q.pop_front());
                  if (!first_seen) begin
                     first_seen = 1;
                     first_type = fifo_dout[48:47];
                  end
                  if (fifo_dout[48:47] == 2'b01) begin
                     last_hdr = fifo_dout;
                     t_hdr = cyc;
                  end
                  if (fifo_dout[48:47] == 2'b11) begin
                     last_trl = fifo_dout;
                     t_trl = cyc;
                  end
               end
            end
         end
      end
   end

   task automatic start_trig(input logic [3:0] id, input int n);
      int k;
      int h;
      logic [46:0] hv;
      k = 0;
      while (!trig_ready && k < 500) begin
         @(negedge clock);
         k++;
      end
      chk("trig_ready_wait", 64'(trig_ready), 64'd1);
      src_q.delete();
      h = (n < MAXH) ? n : MAXH;
      exp_q.push_back({2'b01, 43'b0, id});
      for (int i = 0; i < n; i++) begin
         hv = {10'($urandom), 12'($urandom), 25'($urandom)};
         src_q.push_back(hv);
         if (i < h) exp_q.push_back({2'b10, hv});
      end
      exp_q.push_back({2'b11, 29'b0, 1'(n == 0), 1'(n >= MAXH), 16'(h)});
      edges = 0;
      trig_valid = 1;
      trig_id = id;
      @(negedge clock);
      trig_valid = 0;
      trig_id = 4'($urandom);
   endtask

   // junk trig_valid is only raised while trig_ready is low
   task automatic wait_done(input int budget, input bit junk);
      int k;
      k = 0;
      while (!(exp_q.size() == 0 && trig_ready) && k < budget) begin
         @(negedge clock);
         trig_valid = 0;
         if (junk && !trig_ready && $urandom_range(0, 5) == 0) begin
            trig_valid = 1;
            trig_id = 4'($urandom);
         end
         k++;
      end
      trig_valid = 0;
      chk("trigger_done", 64'(exp_q.size() == 0 && trig_ready), 64'd1);
   endtask

   initial begin
      int k;
      reset = 1;
      trig_valid = 0;
      trig_id = 0;
      tk = 0;
      row_hamm = 0;
      clm_hamm = 0;
      data_hamm = 0;
      f_wr = 0;
      f_din = 0;
      f_rd = 0;
      repeat (3) @(negedge clock);
      chk("rst_ready", 64'(trig_ready), 64'd1);
      chk("rst_read", 64'(read), 64'd0);
      chk("rst_trigid", 64'(TrigIdReq), 64'd0);
      chk("rst_empty", 64'(fifo_empty), 64'd1);
      chk("rst_full", 64'(fifo_full), 64'd0);
      chk("rst_dout", 64'(fifo_dout), 64'd0);
      reset = 0;

      // three pending hits, consumer always ready
      rd_mode = 2;
      start_trig(4'd5, 3);
      wait_done(400, 0);
      chk("t1_hdr", 64'(last_hdr), 64'h0_8000_0000_0005);
      chk("t1_trl", 64'(last_trl), 64'h1_8000_0000_0003);
      chk("t1_edges", 64'(edges), 64'd3);

      // no token: timeout trailer TK_TIMEOUT+1 cycles after header
      start_trig(4'd2, 0);
      wait_done(400, 0);
      chk("t2_trl", 64'(last_trl), 64'h1_8000_0002_0000);
      chk("t2_gap", 64'(t_trl - t_hdr), 64'(TKTO + 1));
      chk("t2_edges", 64'(edges), 64'd0);

      // token held high: stop at MAX_HITS with overflow
      rd_mode = 0;
      start_trig(4'd11, 6);
      wait_done(600, 0);
      repeat (10) @(negedge clock);
      chk("t3_trl", 64'(last_trl), 64'h1_8000_0001_0004);
      chk("t3_edges", 64'(edges), 64'd4);

      // consumer stalled: FSM must park in CAPTURE with read low
      rd_mode = 1;
      start_trig(4'd9, 3);
      repeat (30) @(negedge clock);
      chk("t4_full", 64'(fifo_full), 64'd1);
      for (int i = 0; i < 8; i++) begin
         chk("t4_read_low", 64'(read), 64'd0);
         @(negedge clock);
      end
      chk("t4_edges", 64'(edges), 64'd2);
      rd_mode = 2;
      wait_done(400, 0);
      chk("t4_trl", 64'(last_trl), 64'h1_8000_0000_0003);

      // standalone fifo: push and pop together while full
      f_wr = 1; f_din = 8'hA1;
      @(negedge clock);
      f_din = 8'hB2;
      @(negedge clock);
      f_wr = 0;
      chk("sf_full", 64'(f_full), 64'd1);
      f_wr = 1; f_rd = 1; f_din = 8'hC3;
      @(negedge clock);
      f_wr = 0;
      chk("sf_full_kept", 64'(f_full), 64'd1);
      chk("sf_next", 64'(f_dout), 64'hB2);
      @(negedge clock);
      chk("sf_last", 64'(f_dout), 64'hC3);
      @(negedge clock);
      f_rd = 0;
      chk("sf_empty", 64'(f_empty), 64'd1);

      // reset while read is in its second (HOLD) cycle
      rd_mode = 2;
      start_trig(4'd7, 3);
      k = 0;
      while (!read && k < 200) begin
         @(negedge clock);
         k++;
      end
      chk("t5_read_seen", 64'(read), 64'd1);
      @(posedge clock);
      #2;
      reset = 1;
      #1;
      chk("t5_read", 64'(read), 64'd0);
      chk("t5_empty", 64'(fifo_empty), 64'd1);
      chk("t5_full", 64'(fifo_full), 64'd0);
      chk("t5_dout", 64'(fifo_dout), 64'd0);
      chk("t5_trigid", 64'(TrigIdReq), 64'd0);
      exp_q.delete();
      src_q.delete();
      @(negedge clock);
      @(negedge clock);
      reset = 0;
      first_seen = 0;
      start_trig(4'd3, 2);
      wait_done(400, 0);
      chk("t5_first_hdr", 64'(first_type), 64'd1);
      chk("t5_trl", 64'(last_trl), 64'h1_8000_0000_0002);

      // randomised triggers with random consumer and ignored trig_valid
      rd_mode = 0;
      for (int t = 0; t < 25; t++) begin
         start_trig(4'($urandom), $urandom_range(0, 6));
         wait_done(1500, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
